// File: rtl/timer_irq_ctrl.sv
// Timer/Counter0 interrupt sequencer: qualifies TIFR with TIMSK and SREG.I, arbitrates
// OCF0A > OCF0B > TOV0, and runs the req/ack/RETI handshake with the CPU.
module timer_irq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_WIDTH  = 5,
  parameter int VEC_COMPA  = 8,
  parameter int VEC_COMPB  = 9,
  parameter int VEC_OVF    = 10,
  parameter int GAP_CYCLES = 1,
  parameter int BIT_TOV0   = 0,
  parameter int BIT_OCF0A  = 1,
  parameter int BIT_OCF0B  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tifr,
  input  logic [DATA_WIDTH-1:0] timsk,
  input  logic                  sreg_i,
  input  logic                  irq_ack,
  input  logic                  reti,
  output logic                  irq_req,
  output logic [VEC_WIDTH-1:0]  irq_vector,
  output logic [DATA_WIDTH-1:0] flag_clr,
  output logic                  in_service
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  logic [1:0]            state;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] win_q;
  logic [DATA_WIDTH-1:0] src_mask;
  logic [DATA_WIDTH-1:0] pend;
  logic [DATA_WIDTH-1:0] win_bit;
  logic [VEC_WIDTH-1:0]  win_vec;
  logic                  win_pending;

  // Only the three Timer0 flag positions can raise a request.
  always_comb begin
    src_mask            = '0;
    src_mask[BIT_TOV0]  = 1'b1;
    src_mask[BIT_OCF0A] = 1'b1;
    src_mask[BIT_OCF0B] = 1'b1;
    pend                = tifr & timsk & src_mask;
  end

  always_comb begin
    win_bit = '0;
    win_vec = '0;
    if (pend[BIT_OCF0A]) begin
      win_bit[BIT_OCF0A] = 1'b1;
      win_vec            = VEC_WIDTH'(VEC_COMPA);
    end else if (pend[BIT_OCF0B]) begin
      win_bit[BIT_OCF0B] = 1'b1;
      win_vec            = VEC_WIDTH'(VEC_COMPB);
    end else if (pend[BIT_TOV0]) begin
      win_bit[BIT_TOV0] = 1'b1;
      win_vec           = VEC_WIDTH'(VEC_OVF);
    end
  end

  assign win_pending = |(pend & win_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      flag_clr   <= '0;
      in_service <= 1'b0;
      gap_cnt    <= '0;
      win_q      <= '0;
    end else begin
      flag_clr <= '0;
      case (state)
        S_IDLE: begin
          if (sreg_i && (|pend)) begin
            win_q      <= win_bit;
            irq_vector <= win_vec;
            irq_req    <= 1'b1;
            state      <= S_REQ;
          end
        end
        // The latched winner is held; a higher-priority arrival waits its turn.
        S_REQ: begin
          if (irq_ack) begin
            irq_req    <= 1'b0;
            irq_vector <= '0;
            flag_clr   <= win_q;
            in_service <= 1'b1;
            state      <= S_SERVICE;
          end else if (!win_pending || !sreg_i) begin
            irq_req    <= 1'b0;
            irq_vector <= '0;
            state      <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (reti) begin
            in_service <= 1'b0;
            gap_cnt    <= GW'(GAP_CYCLES);
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt > GW'(1)) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
